// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: state encoding,
// nibble width and the leading-zero blanking helper.
package seven_seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_e;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 8;

    // 1 when digit idx and every more significant digit below ndig are zero
    function automatic logic lz_blank(input logic [31:0] nibs, input int idx, input int ndig);
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i >= idx && i < ndig && nibs[4*i +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end else begin
                all_zero = all_zero;
            end
        end
        return (idx != 0) && all_zero;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_tick_gen.sv
// Dwell prescaler: counts while clr is low and flags the last cycle of a
// CLK_DIV-cycle digit visit.
module scan_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count_r;

    // Free-running counter reset by clr (also applied at every wrap by the parent)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tick = (count_r == CW'(CLK_DIV - 1));

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-seg bank: double-buffered
// value, guard gap between digits and optional leading-zero blanking.
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD_CYC  = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        load,
    input  logic [NIB_W*NUM_DIGITS-1:0] value,
    output logic                        load_ack,
    output logic [NUM_DIGITS-1:0]       an,
    output logic [NIB_W-1:0]            seg_num,
    output logic                        seg_enable,
    output logic                        frame_done
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int VW = NIB_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{1'b1}};

    scan_state_e     state_r, state_s;
    logic [IW-1:0]   idx_r, idx_s;
    logic [VW-1:0]   shadow_r, shadow_s, pending_r, pending_s;
    logic            shadow_vld_r, shadow_vld_s, pending_vld_r, pending_vld_s;
    logic [GW-1:0]   gcnt_r, gcnt_s;
    logic [NUM_DIGITS-1:0] an_s;
    logic [NIB_W-1:0] seg_num_s;
    logic            seg_enable_s, load_ack_s, frame_done_s;
    logic            tick_s, clr_s, advance_s, commit_s;
    logic [31:0]     shadow_ext_s;

    assign clr_s = (state_r != ST_DRIVE) || tick_s;

    scan_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Next-state, buffer and output decode; outputs derive from next state so they register in step
    always_comb begin
        state_s       = state_r;
        idx_s         = idx_r;
        shadow_s      = shadow_r;
        shadow_vld_s  = shadow_vld_r;
        pending_s     = pending_r;
        pending_vld_s = pending_vld_r;
        gcnt_s        = {GW{1'b0}};
        load_ack_s    = 1'b0;
        frame_done_s  = 1'b0;
        advance_s     = 1'b0;
        commit_s      = 1'b0;

        case (state_r)
            ST_OFF: begin
                if (load) begin
                    shadow_s     = value;
                    shadow_vld_s = 1'b1;
                    load_ack_s   = 1'b1;
                end else begin
                    shadow_s = shadow_r;
                end
                if (en && shadow_vld_r) begin
                    state_s = ST_DRIVE;
                    idx_s   = {IW{1'b0}};
                end else begin
                    state_s = ST_OFF;
                end
            end
            ST_DRIVE: begin
                if (tick_s) begin
                    if (GUARD_CYC == 0) begin
                        advance_s = 1'b1;
                    end else begin
                        state_s = ST_GUARD;
                    end
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_GUARD: begin
                if (gcnt_r == GW'(GUARD_CYC - 1)) begin
                    advance_s = 1'b1;
                end else begin
                    gcnt_s = gcnt_r + GW'(1);
                end
            end
            default: begin
                state_s = ST_OFF;
                idx_s   = {IW{1'b0}};
            end
        endcase

        if (advance_s) begin
            state_s = ST_DRIVE;
            if (idx_r == IW'(NUM_DIGITS - 1)) begin
                idx_s        = {IW{1'b0}};
                frame_done_s = 1'b1;
                commit_s     = 1'b1;
            end else begin
                idx_s = idx_r + IW'(1);
            end
        end else begin
            commit_s = 1'b0;
        end

        // Turning the display off flushes any pending value into the shadow
        if (state_r != ST_OFF) begin
            if (!en) begin
                state_s      = ST_OFF;
                idx_s        = {IW{1'b0}};
                gcnt_s       = {GW{1'b0}};
                frame_done_s = 1'b0;
                commit_s     = 1'b1;
            end else begin
                state_s = state_s;
            end
            if (commit_s) begin
                if (load) begin
                    shadow_s   = value;
                    load_ack_s = 1'b1;
                end else if (pending_vld_r) begin
                    shadow_s   = pending_r;
                    load_ack_s = 1'b1;
                end else begin
                    shadow_s = shadow_r;
                end
                pending_vld_s = 1'b0;
            end else if (load) begin
                pending_s     = value;
                pending_vld_s = 1'b1;
            end else begin
                pending_s = pending_r;
            end
        end else begin
            pending_vld_s = pending_vld_r;
        end

        shadow_ext_s = 32'(shadow_s);
        an_s         = AN_OFF;
        seg_num_s    = seg_num;
        seg_enable_s = 1'b0;
        if (state_s == ST_DRIVE) begin
            an_s[idx_s]  = 1'b0;
            seg_num_s    = shadow_s[NIB_W*idx_s +: NIB_W];
            seg_enable_s = !((LZ_BLANK != 0) && lz_blank(shadow_ext_s, int'(idx_s), NUM_DIGITS));
        end else begin
            seg_enable_s = 1'b0;
        end
    end

    // State, buffers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_OFF;
            idx_r         <= {IW{1'b0}};
            shadow_r      <= {VW{1'b0}};
            shadow_vld_r  <= 1'b0;
            pending_r     <= {VW{1'b0}};
            pending_vld_r <= 1'b0;
            gcnt_r        <= {GW{1'b0}};
            an            <= AN_OFF;
            seg_num       <= {NIB_W{1'b0}};
            seg_enable    <= 1'b0;
            load_ack      <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_r       <= state_s;
            idx_r         <= idx_s;
            shadow_r      <= shadow_s;
            shadow_vld_r  <= shadow_vld_s;
            pending_r     <= pending_s;
            pending_vld_r <= pending_vld_s;
            gcnt_r        <= gcnt_s;
            an            <= an_s;
            seg_num       <= seg_num_s;
            seg_enable    <= seg_enable_s;
            load_ack      <= load_ack_s;
            frame_done    <= frame_done_s;
        end
    end

endmodule
